// File: rtl/rule_confirm_if.sv
// Search/segment/confirm bundle for rule_confirm.
// Optional macro RULE_CONFIRM_MATCH_COUNT_EN adds the o_match_count signal.
interface rule_confirm_if #(
    parameter int DATA_BITS = 10,
    parameter int IDWID     = 2,
    parameter int MASKWID   = 5
);
    localparam int KWID    = DATA_BITS;
    localparam int PRIOWID = IDWID;
    localparam int SEGWID  = 2 + IDWID + MASKWID + KWID + PRIOWID;

    logic [KWID-1:0]    i_search_key;
    logic               i_search_valid;
    logic               o_search_ready;
    logic [SEGWID-1:0]  i_seg_data;
    logic               i_seg_valid;
    logic               i_seg_last;
    logic               o_seg_ready;
    logic [IDWID-1:0]   o_confirm_ruleid;
    logic [PRIOWID-1:0] o_confirm_priority;
    logic               o_confirm_valid;
    logic               o_confirm_complete;
    logic               i_priority_complete;
`ifdef RULE_CONFIRM_MATCH_COUNT_EN
    logic [IDWID+1:0]   o_match_count;
`endif

    modport master (
        output i_search_key, i_search_valid, i_seg_data, i_seg_valid, i_seg_last,
        output i_priority_complete,
        input  o_search_ready, o_seg_ready, o_confirm_ruleid, o_confirm_priority,
        input  o_confirm_valid, o_confirm_complete
`ifdef RULE_CONFIRM_MATCH_COUNT_EN
        , input o_match_count
`endif
    );

    modport slave (
        input  i_search_key, i_search_valid, i_seg_data, i_seg_valid, i_seg_last,
        input  i_priority_complete,
        output o_search_ready, o_seg_ready, o_confirm_ruleid, o_confirm_priority,
        output o_confirm_valid, o_confirm_complete
`ifdef RULE_CONFIRM_MATCH_COUNT_EN
        , output o_match_count
`endif
    );
endinterface

// File: rtl/rule_confirm.sv
// rule_confirm: compares a stream of candidate rule segments against a captured
// search key, pulses the ID/priority of every match, then signals completion
// three cycles after the last segment so the priority engine can settle.
// Optional macro RULE_CONFIRM_MATCH_COUNT_EN adds a saturating match counter.
module rule_confirm #(
    parameter int DATA_BITS = 10,
    parameter int IDWID     = 2,
    parameter int MASKWID   = 5
) (
    input  logic          clk,
    input  logic          reset,
    rule_confirm_if.slave bus
);
    localparam int KWID    = DATA_BITS;
    localparam int PRIOWID = IDWID;
    localparam int SEGWID  = 2 + IDWID + MASKWID + KWID + PRIOWID;
    localparam int G       = KWID / MASKWID;

    typedef enum logic [2:0] {IDLE, SCAN, FLUSH, REPORT, HOLD} state_t;

    state_t              state, state_nxt;
    logic                flush_cnt;
    logic [KWID-1:0]     key_q;
    logic [1:0]          seg_status;
    logic [IDWID-1:0]    seg_id;
    logic [MASKWID-1:0]  seg_mask;
    logic [KWID-1:0]     seg_key;
    logic [PRIOWID-1:0]  seg_prio;
    logic                search_hs;
    logic                seg_hs;
    logic                seg_match;

    assign seg_status = bus.i_seg_data[SEGWID-1 -: 2];
    assign seg_id     = bus.i_seg_data[SEGWID-3 -: IDWID];
    assign seg_mask   = bus.i_seg_data[PRIOWID+KWID +: MASKWID];
    assign seg_key    = bus.i_seg_data[PRIOWID +: KWID];
    assign seg_prio   = bus.i_seg_data[PRIOWID-1:0];

    assign search_hs = bus.i_search_valid & bus.o_search_ready;
    assign seg_hs    = bus.i_seg_valid & bus.o_seg_ready;

    // Segment match: valid status and every unmasked key group equal.
    always_comb begin
        seg_match = (seg_status == 2'b01);
        for (int unsigned i = 0; i < MASKWID; i++) begin
            if (!seg_mask[i] && (seg_key[i*G +: G] != key_q[i*G +: G])) begin
                seg_match = 1'b0;
            end
        end
    end

    // State register and two-cycle FLUSH counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            flush_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
        end
    end

    // Next-state and state-decoded handshake/complete outputs.
    // Transitions use the raw valids: the matching ready is implied by the state.
    always_comb begin
        state_nxt              = state;
        bus.o_search_ready     = 1'b0;
        bus.o_seg_ready        = 1'b0;
        bus.o_confirm_complete = 1'b0;
        case (state)
            IDLE: begin
                bus.o_search_ready = 1'b1;
                if (bus.i_search_valid) state_nxt = SCAN;
            end
            SCAN: begin
                bus.o_seg_ready = 1'b1;
                if (bus.i_seg_valid && bus.i_seg_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (flush_cnt) state_nxt = REPORT;
            end
            REPORT: begin
                bus.o_confirm_complete = 1'b1;
                if (bus.i_priority_complete) state_nxt = HOLD;
            end
            HOLD: begin
                bus.o_search_ready     = 1'b1;
                bus.o_confirm_complete = 1'b1;
                if (bus.i_search_valid) state_nxt = SCAN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the search key on the search handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q <= '0;
        end else if (search_hs) begin
            key_q <= bus.i_search_key;
        end
    end

    // Registered confirm pulse; ID and priority hold until the next match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.o_confirm_valid    <= 1'b0;
            bus.o_confirm_ruleid   <= '0;
            bus.o_confirm_priority <= '0;
        end else begin
            bus.o_confirm_valid <= seg_hs & seg_match;
            if (seg_hs && seg_match) begin
                bus.o_confirm_ruleid   <= seg_id;
                bus.o_confirm_priority <= seg_prio;
            end
        end
    end

`ifdef RULE_CONFIRM_MATCH_COUNT_EN
    // Saturating count of confirm pulses in the current search.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.o_match_count <= '0;
        end else if (search_hs) begin
            bus.o_match_count <= '0;
        end else if (bus.o_confirm_valid && (bus.o_match_count != '1)) begin
            bus.o_match_count <= bus.o_match_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_rule_confirm.sv
// Self-checking bench for rule_confirm: directed scenarios plus randomized
// searches checked against a rule-level match model.
module tb_rule_confirm;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [1:0]  exp_id;
    logic [1:0]  exp_prio;
    int          exp_cnt;
    logic [20:0] segs [0:31];

    rule_confirm_if #(.DATA_BITS(10), .IDWID(2), .MASKWID(5)) bus ();

    rule_confirm #(.DATA_BITS(10), .IDWID(2), .MASKWID(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [20:0] mkseg(input logic [1:0] st, input logic [1:0] id,
                                         input logic [4:0] mask, input logic [9:0] key,
                                         input logic [1:0] pr);
        return {st, id, mask, key, pr};
    endfunction

    // Rule-level match: status must be valid, each unmasked 2-bit group equal.
    function automatic bit model_match(input logic [9:0] key, input logic [20:0] seg);
        logic [9:0] skey;
        logic [4:0] mask;
        if (seg[20:19] != 2'b01) return 1'b0;
        mask = seg[16:12];
        skey = seg[11:2];
        for (int i = 0; i < 5; i++) begin
            if (mask[i] == 1'b0 && ((key >> (2 * i)) & 10'd3) != ((skey >> (2 * i)) & 10'd3))
                return 1'b0;
        end
        return 1'b1;
    endfunction

    // Runs one full search (handshake, segments, flush, report, hold) with inline checks.
    task automatic do_search(input logic [9:0] key, input int nseg, input bit gaps);
        int guard;
        int ngap;
        bit m;
        bus.i_search_key   = key;
        bus.i_search_valid = 1'b1;
        guard = 0;
        while (bus.o_search_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        n_cmp++;
        if (bus.o_search_ready !== 1'b1) begin
            n_err++;
            $display("FAIL search_ready_wait: got %b want 1", bus.o_search_ready);
            bus.i_search_valid = 1'b0;
            return;
        end
        step();
        n_cmp++;
        if ({bus.o_search_ready, bus.o_seg_ready, bus.o_confirm_complete} !== 3'b010) begin
            n_err++;
            $display("FAIL after_search_hs {srdy,segrdy,cmpl}: got %b want 010",
                     {bus.o_search_ready, bus.o_seg_ready, bus.o_confirm_complete});
        end
        exp_cnt = 0;
        bus.i_search_valid = 1'b0;
        bus.i_search_key   = 10'($urandom);
        for (int k = 0; k < nseg; k++) begin
            if (gaps) begin
                ngap = $urandom_range(0, 2);
                repeat (ngap) begin
                    bus.i_seg_valid = 1'b0;
                    bus.i_seg_data  = 21'($urandom);
                    bus.i_seg_last  = 1'($urandom);
                    step();
                    n_cmp++;
                    if ({bus.o_confirm_valid, bus.o_confirm_complete, bus.o_seg_ready} !== 3'b001 ||
                        {bus.o_confirm_ruleid, bus.o_confirm_priority} !== {exp_id, exp_prio}) begin
                        n_err++;
                        $display("FAIL gap_stall {vld,cmpl,segrdy,id,prio}: got %b_%h want 001_%h",
                                 {bus.o_confirm_valid, bus.o_confirm_complete, bus.o_seg_ready},
                                 {bus.o_confirm_ruleid, bus.o_confirm_priority}, {exp_id, exp_prio});
                    end
                end
            end
            bus.i_seg_data     = segs[k];
            bus.i_seg_valid    = 1'b1;
            bus.i_seg_last     = (k == nseg - 1);
            bus.i_search_valid = 1'($urandom);
            bus.i_search_key   = 10'($urandom);
            step();
            m = model_match(key, segs[k]);
            if (m) begin
                exp_id   = segs[k][18:17];
                exp_prio = segs[k][1:0];
                if (exp_cnt < 15) exp_cnt++;
            end
            n_cmp++;
            if (bus.o_confirm_valid !== m) begin
                n_err++;
                $display("FAIL confirm_valid seg%0d: got %b want %b", k, bus.o_confirm_valid, m);
            end
            n_cmp++;
            if ({bus.o_confirm_ruleid, bus.o_confirm_priority} !== {exp_id, exp_prio}) begin
                n_err++;
                $display("FAIL id_prio seg%0d: got %h/%h want %h/%h", k, bus.o_confirm_ruleid,
                         bus.o_confirm_priority, exp_id, exp_prio);
            end
            n_cmp++;
            if (bus.o_confirm_complete !== 1'b0) begin
                n_err++;
                $display("FAIL complete_early seg%0d: got %b want 0", k, bus.o_confirm_complete);
            end
        end
        // Now at L+1; a would-be-matching segment offered in FLUSH must be ignored.
        bus.i_search_valid = 1'b0;
        bus.i_seg_valid    = 1'($urandom);
        bus.i_seg_data     = mkseg(2'b01, 2'd1, 5'h1F, key, 2'd1);
        bus.i_seg_last     = 1'b1;
        step();
        n_cmp++;
        if ({bus.o_confirm_valid, bus.o_confirm_complete, bus.o_seg_ready, bus.o_search_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL flush_L2 {vld,cmpl,segrdy,srdy}: got %b want 0000",
                     {bus.o_confirm_valid, bus.o_confirm_complete, bus.o_seg_ready, bus.o_search_ready});
        end
        step();
        n_cmp++;
        if ({bus.o_confirm_valid, bus.o_confirm_complete} !== 2'b01) begin
            n_err++;
            $display("FAIL complete_L3 {vld,cmpl}: got %b want 01",
                     {bus.o_confirm_valid, bus.o_confirm_complete});
        end
`ifdef RULE_CONFIRM_MATCH_COUNT_EN
        n_cmp++;
        if (bus.o_match_count !== 4'(exp_cnt)) begin
            n_err++;
            $display("FAIL match_count: got %0d want %0d", bus.o_match_count, exp_cnt);
        end
`endif
        // A search request in REPORT must be ignored.
        bus.i_seg_valid    = 1'b0;
        bus.i_search_valid = 1'b1;
        step();
        n_cmp++;
        if ({bus.o_confirm_complete, bus.o_search_ready, bus.o_seg_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL report_ignore {cmpl,srdy,segrdy}: got %b want 100",
                     {bus.o_confirm_complete, bus.o_search_ready, bus.o_seg_ready});
        end
        bus.i_search_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
        bus.i_priority_complete = 1'b1;
        step();
        bus.i_priority_complete = 1'b0;
        n_cmp++;
        if ({bus.o_search_ready, bus.o_confirm_complete, bus.o_confirm_valid} !== 3'b110 ||
            {bus.o_confirm_ruleid, bus.o_confirm_priority} !== {exp_id, exp_prio}) begin
            n_err++;
            $display("FAIL hold_state {srdy,cmpl,vld,id,prio}: got %b_%h want 110_%h",
                     {bus.o_search_ready, bus.o_confirm_complete, bus.o_confirm_valid},
                     {bus.o_confirm_ruleid, bus.o_confirm_priority}, {exp_id, exp_prio});
        end
`ifdef RULE_CONFIRM_MATCH_COUNT_EN
        n_cmp++;
        if (bus.o_match_count !== 4'(exp_cnt)) begin
            n_err++;
            $display("FAIL match_count_hold: got %0d want %0d", bus.o_match_count, exp_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.o_search_ready, bus.o_seg_ready, bus.o_confirm_valid, bus.o_confirm_complete} !== 4'b1000 ||
            {bus.o_confirm_ruleid, bus.o_confirm_priority} !== 4'h0) begin
            n_err++;
            $display("FAIL reset_values {srdy,segrdy,vld,cmpl,id,prio}: got %b_%h want 1000_0",
                     {bus.o_search_ready, bus.o_seg_ready, bus.o_confirm_valid, bus.o_confirm_complete},
                     {bus.o_confirm_ruleid, bus.o_confirm_priority});
        end
`ifdef RULE_CONFIRM_MATCH_COUNT_EN
        n_cmp++;
        if (bus.o_match_count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d want 0", bus.o_match_count);
        end
`endif
        exp_id = 2'd0; exp_prio = 2'd0; exp_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        step();
        n_cmp++;
        if ({bus.o_search_ready, bus.o_seg_ready, bus.o_confirm_complete} !== 3'b100) begin
            n_err++;
            $display("FAIL idle_after_reset {srdy,segrdy,cmpl}: got %b want 100",
                     {bus.o_search_ready, bus.o_seg_ready, bus.o_confirm_complete});
        end
    endtask

    task automatic test_basic();
        segs[0] = mkseg(2'b01, 2'd2, 5'h00, 10'h2A5, 2'd3);
        do_search(10'h2A5, 1, 1'b0);
    endtask

    task automatic test_mask();
        segs[0] = mkseg(2'b01, 2'd1, 5'h01, 10'h2A6, 2'd0);
        do_search(10'h2A5, 1, 1'b0);
        segs[0] = mkseg(2'b01, 2'd3, 5'h00, 10'h2A6, 2'd2);
        do_search(10'h2A5, 1, 1'b0);
    endtask

    task automatic test_status();
        segs[0] = mkseg(2'b10, 2'd3, 5'h00, 10'h2A5, 2'd1);
        segs[1] = mkseg(2'b00, 2'd2, 5'h1F, 10'h000, 2'd1);
        segs[2] = mkseg(2'b11, 2'd1, 5'h00, 10'h2A5, 2'd2);
        do_search(10'h2A5, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        segs[0] = mkseg(2'b01, 2'd1, 5'h00, 10'h155, 2'd2);
        segs[1] = mkseg(2'b00, 2'd2, 5'h00, 10'h155, 2'd1);
        segs[2] = mkseg(2'b01, 2'd3, 5'h1C, 10'h3F5, 2'd0);
        do_search(10'h155, 3, 1'b0);
    endtask

    task automatic test_hold_restart();
        segs[0] = mkseg(2'b01, 2'd0, 5'h00, 10'h000, 2'd1);
        segs[1] = mkseg(2'b01, 2'd2, 5'h00, 10'h001, 2'd3);
        do_search(10'h000, 2, 1'b1);
        do_search(10'h000, 2, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus.i_search_key   = 10'h0F0;
        bus.i_search_valid = 1'b1;
        step();
        bus.i_search_valid = 1'b0;
        bus.i_seg_data  = mkseg(2'b01, 2'd1, 5'h00, 10'h0F0, 2'd2);
        bus.i_seg_valid = 1'b1;
        bus.i_seg_last  = 1'b0;
        step();
        n_cmp++;
        if ({bus.o_confirm_valid, bus.o_confirm_ruleid, bus.o_confirm_priority} !== 5'b1_01_10) begin
            n_err++;
            $display("FAIL midsearch_pulse {vld,id,prio}: got %b want 10110",
                     {bus.o_confirm_valid, bus.o_confirm_ruleid, bus.o_confirm_priority});
        end
        bus.i_seg_data = mkseg(2'b01, 2'd3, 5'h00, 10'h0F0, 2'd3);
        #2;
        reset = 1'b1;
        #1;
        exp_id = 2'd0; exp_prio = 2'd0; exp_cnt = 0;
        n_cmp++;
        if ({bus.o_search_ready, bus.o_seg_ready, bus.o_confirm_valid, bus.o_confirm_complete} !== 4'b1000 ||
            {bus.o_confirm_ruleid, bus.o_confirm_priority} !== 4'h0) begin
            n_err++;
            $display("FAIL async_reset {srdy,segrdy,vld,cmpl,id,prio}: got %b_%h want 1000_0",
                     {bus.o_search_ready, bus.o_seg_ready, bus.o_confirm_valid, bus.o_confirm_complete},
                     {bus.o_confirm_ruleid, bus.o_confirm_priority});
        end
        @(negedge clk);
        reset = 1'b0;
        bus.i_seg_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if ({bus.o_search_ready, bus.o_seg_ready, bus.o_confirm_valid, bus.o_confirm_complete} !== 4'b1000) begin
                n_err++;
                $display("FAIL post_reset_idle c%0d {srdy,segrdy,vld,cmpl}: got %b want 1000", c,
                         {bus.o_search_ready, bus.o_seg_ready, bus.o_confirm_valid, bus.o_confirm_complete});
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] key;
        logic [1:0] st;
        logic [9:0] skey;
        int nseg;
        for (int it = 0; it < 10; it++) begin
            key  = 10'($urandom);
            nseg = $urandom_range(1, 8);
            for (int k = 0; k < nseg; k++) begin
                st   = ($urandom_range(0, 2) != 0) ? 2'b01 : 2'($urandom);
                skey = ($urandom_range(0, 1) != 0) ? (key ^ (10'($urandom) & 10'($urandom) & 10'($urandom)))
                                                   : 10'($urandom);
                segs[k] = mkseg(st, 2'($urandom), 5'($urandom), skey, 2'($urandom));
            end
            do_search(key, nseg, 1'b1);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 18; k++) begin
            segs[k] = mkseg(2'b01, 2'($urandom), 5'h1F, 10'($urandom), 2'($urandom));
        end
        do_search(10'($urandom), 18, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.i_search_key        = '0;
        bus.i_search_valid      = 1'b0;
        bus.i_seg_data          = '0;
        bus.i_seg_valid         = 1'b0;
        bus.i_seg_last          = 1'b0;
        bus.i_priority_complete = 1'b0;
        test_reset();
        test_basic();
        test_mask();
        test_status();
        test_back_to_back();
        test_hold_restart();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rule_confirm.md
RULE_CONFIRM -- requirements
Module: rule_confirm

Interface
REQ-001 Parameter DATA_BITS, 10, search/rule key width (KWID); SHALL be an integer multiple of MASKWID.
REQ-002 Parameter IDWID, 2, rule ID width; priority width PRIOWID SHALL equal IDWID.
REQ-003 Parameter MASKWID, 5, mask width; each mask bit covers KWID/MASKWID adjacent key bits, with mask bit i covering key bits [(i+1)*G-1 : i*G], where G = KWID/MASKWID.
REQ-004 Segment width SEGWID SHALL be 2+IDWID+MASKWID+KWID+PRIOWID; fields from MSB to LSB are status[2], ID, MASK, KEY, PRIORITY.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 i_search_key  in  KWID  search key, sampled on the search handshake.
REQ-009 i_search_valid  in  1  search request.
REQ-010 o_search_ready  out  1  block accepts a search.
REQ-011 i_seg_data  in  SEGWID  candidate rule segment.
REQ-012 i_seg_valid / i_seg_last  in  1 each  segment valid / last segment of the search.
REQ-013 o_seg_ready  out  1  segment accepted when i_seg_valid&o_seg_ready.
REQ-014 o_confirm_ruleid / o_confirm_priority  out  IDWID / PRIOWID  ID and priority of the matched rule.
REQ-015 o_confirm_valid  out  1  one-cycle pulse per matching segment.
REQ-016 o_confirm_complete  out  1  level signal indicating the search is finished.
REQ-017 i_priority_complete  in  1  one-cycle pulse from the priority engine indicating the final ID is registered.

Function
REQ-018 States SHALL be IDLE, SCAN, FLUSH, REPORT and HOLD.
- IDLE->SCAN and HOLD->SCAN on search handshake.
- SCAN->FLUSH on the handshake of a segment with i_seg_last=1.
- FLUSH lasts exactly 2 cycles, then goes to REPORT.
- REPORT->HOLD on i_priority_complete.
REQ-019 o_search_ready SHALL be 1 only in IDLE and HOLD; o_seg_ready SHALL be 1 only in SCAN.
REQ-020 A segment SHALL match when status==2'b01 and, for every mask bit that is 0, the covered bits of the segment KEY equal the captured search key; a mask bit of 1 means don't-care.
- Status values 00 (empty), 10 (deleted) and 11 (reserved) SHALL never match.
REQ-021 A segment handshake at cycle t that matches SHALL produce o_confirm_valid=1 at cycle t+1, with o_confirm_ruleid and o_confirm_priority taken from that segment.
- ID and priority SHALL hold their values until the next match.
- Priority SHALL be forwarded unmodified; priority 0 is legal.
REQ-022 If the last segment is accepted at cycle L, o_confirm_complete SHALL rise at cycle L+3.
- This guarantees at least one idle cycle between the final o_confirm_valid and the complete edge, so the priority engine's last compare settles before capture.
REQ-023 o_confirm_valid SHALL never be 1 while o_confirm_complete is 1.
REQ-024 o_confirm_complete SHALL stay 1 through REPORT and HOLD, and SHALL fall in the cycle after the next search handshake.
REQ-025 Back-to-back segments, one per cycle, SHALL be sustained; gaps with i_seg_valid=0 SHALL stall SCAN without any output effect.
REQ-026 i_seg_valid outside SCAN SHALL be ignored; i_search_valid outside IDLE/HOLD SHALL be ignored.
REQ-027 A search with no matching segment SHALL still complete at cycle L+3, with no o_confirm_valid pulse.

Reset
REQ-028 On reset the block SHALL enter IDLE and clear the captured key, ID, priority and the FLUSH counter.
- Reset values: o_search_ready=1, o_seg_ready=0, o_confirm_valid=0, o_confirm_complete=0, o_confirm_ruleid=0, o_confirm_priority=0.
REQ-029 Reset asserted mid-search SHALL abandon the search immediately; in-flight segments are dropped and no complete edge is produced.

Configuration
REQ-030 Macro RULE_CONFIRM_MATCH_COUNT_EN SHALL control a match counter.
- Defined: adds output o_match_count[IDWID+1:0], which clears on the search handshake, increments on each o_confirm_valid, saturates at all-ones, is held through HOLD, and resets to 0.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Verification (DATA_BITS=10, IDWID=2, MASKWID=5, SEGWID=21)
REQ-031 Search key 10'h2A5; one segment {01,2'd2,5'h00,10'h2A5,2'd3} with last -> o_confirm_valid at L+1 with ID 2, priority 3; o_confirm_complete rises at L+3.
REQ-032 Key 10'h2A5 against segment key 10'h2A6 -> with mask 5'h01, match (pulse); with mask 5'h00, no pulse, and complete still rises at L+3.
REQ-033 Matching key and mask with status 2'b10 -> no o_confirm_valid; complete rises at L+3.
REQ-034 Three consecutive segments, matching on segments 1 and 3 (IDs 1 and 3) -> pulses at L-1 and L+1; ID stays 1 at cycle L; complete rises at L+3; o_match_count=2 when the macro is defined.
REQ-035 Reset asserted in SCAN after 1 of 3 segments -> next cycle shows IDLE, o_seg_ready=0, all outputs at reset values, no complete edge.
REQ-036 From HOLD, i_search_valid=1 with key 10'h000 -> o_search_ready drops, o_confirm_complete falls the next cycle, and the new scan proceeds normally.
